// File: rtl/quadrature_updown_decoder_if.sv
// quadrature_updown_decoder_if: encoder phases and clear in, position count and status pulses out.
interface quadrature_updown_decoder_if #(parameter int WIDTH = 3);
   logic a, b, clr;
   logic [WIDTH-1:0] count;
   logic m, step, err;
   modport master (output a, b, clr, input count, m, step, err);
   modport slave (input a, b, clr, output count, m, step, err);
endinterface

// File: rtl/quadrature_updown_decoder.sv
// quadrature_updown_decoder: synchronized quadrature phase decoder with wrapping up/down position count.
module quadrature_updown_decoder #(parameter int WIDTH = 3) (
   input logic clk,
   input logic reset,
   quadrature_updown_decoder_if.slave bus
);
   typedef enum logic [1:0] {INIT0, INIT1, RUN} state_t;
   state_t state, state_nx;
   logic [1:0] s1, s2, prev, prev_nx;
   logic [WIDTH-1:0] count, count_nx;
   logic m, m_nx, step, step_nx, err, err_nx, run, up, dn;
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         state <= INIT0;
         s1 <= '0;
         s2 <= '0;
         prev <= '0;
         count <= '0;
         m <= 1'b0;
         step <= 1'b0;
         err <= 1'b0;
      end else begin
         state <= state_nx;
         s1 <= {bus.a, bus.b};
         s2 <= s1;
         prev <= prev_nx;
         count <= count_nx;
         m <= m_nx;
         step <= step_nx;
         err <= err_nx;
      end
   // INIT1 seeds prev with the pair that cur holds on RUN entry, so a static
   // non-zero encoder position never looks like a transition out of reset.
   always_comb begin
      run = state == RUN;
      up = {prev, s2} inside {4'b0010, 4'b1011, 4'b1101, 4'b0100};
      dn = {prev, s2} inside {4'b0001, 4'b0111, 4'b1110, 4'b1000};
      state_nx = state == INIT0 ? INIT1 : RUN;
      prev_nx = state == INIT0 ? prev : state == INIT1 ? s1 : s2;
      step_nx = run && (up || dn);
      err_nx = run && (&(prev ^ s2));
      m_nx = run && up ? 1'b0 : run && dn ? 1'b1 : m;
      count_nx = bus.clr ? '0 : run && up ? count + WIDTH'(1) : run && dn ? count - WIDTH'(1) : count;
   end
   assign bus.count = count;
   assign bus.m = m;
   assign bus.step = step;
   assign bus.err = err;
endmodule

// File: tb/tb_quadrature_updown_decoder.sv
// tb_quadrature_updown_decoder: scoreboard bench; predicted transitions queue up at drive time and are checked two edges later.
module tb_quadrature_updown_decoder;
   localparam int W = 3;
   logic clk = 1'b0;
   logic reset = 1'b0;
   int n_tests = 0;
   int n_fail = 0;
   int k = 0;
   int sb[$];
   logic [1:0] last_in = '0;
   logic [W-1:0] exp_cnt = '0;
   logic exp_m = 1'b0;
   quadrature_updown_decoder_if #(.WIDTH(W)) bus ();
   quadrature_updown_decoder #(.WIDTH(W)) dut (.clk(clk), .reset(reset), .bus(bus));
   always #5 clk = ~clk;
   task automatic chk(input string tag, input int got, input int exp);
      n_tests++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask
   // quadrature position index: 00,10,11,01 are phases 0..3 going up
   function automatic int pos(input logic [1:0] ab);
      return ab == 2'b00 ? 0 : ab == 2'b10 ? 1 : ab == 2'b11 ? 2 : 3;
   endfunction
   function automatic int tr_of(input logic [1:0] p, input logic [1:0] c);
      int d;
      d = (pos(c) - pos(p) + 4) % 4;
      return d == 1 ? 1 : d == 3 ? -1 : d == 2 ? 2 : 0;
   endfunction
   task automatic model_reset();
      sb.delete();
      sb.push_back(0);
      sb.push_back(0);
      k = 0;
      exp_cnt = '0;
      exp_m = 1'b0;
   endtask
   task automatic cyc(input logic [1:0] ab, input logic c);
      int tr;
      logic st;
      k++;
      bus.a = ab[1];
      bus.b = ab[0];
      bus.clr = c;
      sb.push_back(k == 1 ? 0 : tr_of(last_in, ab));
      last_in = ab;
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
         chk("sb_empty", 0, 1);
         return;
      end
      tr = sb.pop_front();
      st = tr == 1 || tr == -1;
      if (st) exp_m = tr == -1;
      exp_cnt = c ? '0 : exp_cnt + W'(st ? tr : 0);
      chk("count", int'(bus.count), int'(exp_cnt));
      chk("m", int'(bus.m), int'(exp_m));
      chk("step", int'(bus.step), int'(st));
      chk("err", int'(bus.err), int'(tr == 2));
   endtask
   task automatic hold(input logic [1:0] ab, input int n);
      for (int i = 0; i < n; i++) cyc(ab, 1'b0);
   endtask
   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_count"}, int'(bus.count), 0);
      chk({tag, "_m"}, int'(bus.m), 0);
      chk({tag, "_step"}, int'(bus.step), 0);
      chk({tag, "_err"}, int'(bus.err), 0);
   endtask
   initial begin
      bus.a = 1'b1;
      bus.b = 1'b1;
      bus.clr = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk_reset_outputs("rst");
      reset = 1'b1;
      model_reset();
      hold(2'b11, 7);
      hold(2'b01, 4);
      hold(2'b00, 4);
      cyc(2'b00, 1'b1);
      hold(2'b00, 3);
      hold(2'b10, 4);
      hold(2'b11, 4);
      hold(2'b01, 4);
      hold(2'b00, 4);
      chk("up4_count", int'(bus.count), 4);
      cyc(2'b00, 1'b1);
      hold(2'b00, 3);
      hold(2'b01, 4);
      chk("wrap_count", int'(bus.count), 7);
      chk("wrap_m", int'(bus.m), 1);
      hold(2'b00, 4);
      hold(2'b11, 4);
      hold(2'b01, 4);
      hold(2'b00, 4);
      hold(2'b10, 4);
      hold(2'b11, 4);
      hold(2'b01, 4);
      chk("pre_clr_count", int'(bus.count), 5);
      cyc(2'b00, 1'b0);
      cyc(2'b00, 1'b0);
      cyc(2'b00, 1'b1);
      chk("clr_step_count", int'(bus.count), 0);
      chk("clr_step_pulse", int'(bus.step), 1);
      hold(2'b00, 3);
      hold(2'b10, 4);
      hold(2'b11, 4);
      hold(2'b01, 4);
      chk("pre_rst_count", int'(bus.count), 3);
      reset = 1'b0;
      #1;
      chk_reset_outputs("async_rst");
      @(posedge clk);
      #1;
      chk_reset_outputs("held_rst");
      reset = 1'b1;
      model_reset();
      hold(2'b01, 4);
      hold(2'b00, 4);
      hold(2'b10, 4);
      chk("resume_count", int'(bus.count), 2);
      for (int i = 0; i < 60; i++) cyc(2'($urandom_range(0, 3)), $urandom_range(0, 9) == 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/quadrature_updown_decoder.md
QUADRATURE_UPDOWN_DECODER -- requirements
Module: quadrature_updown_decoder

Parameters
REQ-001 The block SHALL have parameter WIDTH, default 3, giving the width of the position count.

Interface
REQ-002 The block SHALL have port clk, input, 1 bit: single rising-edge clock for all state.
REQ-003 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset (0 = reset asserted).
REQ-004 The block SHALL have port a, input, 1 bit: encoder phase A, asynchronous to clk.
REQ-005 The block SHALL have port b, input, 1 bit: encoder phase B, asynchronous to clk.
REQ-006 The block SHALL have port clr, input, 1 bit: synchronous clear of count, active-high.
REQ-007 The block SHALL have port count, output, WIDTH bits: registered position count.
REQ-008 The block SHALL have port m, output, 1 bit: direction of last valid step (0 = up, 1 = down).
REQ-009 The block SHALL have port step, output, 1 bit: one-cycle pulse on each valid count change.
REQ-010 The block SHALL have port err, output, 1 bit: one-cycle pulse on an illegal transition.

Function
REQ-011 a and b SHALL each pass through a two-flop synchronizer (s1, s2) before use; no other logic SHALL read raw a/b.
REQ-012 The block SHALL hold previous synchronized phase pair prev = {A,B}, updated every RUN cycle to current s2 pair cur.
REQ-013 The FSM SHALL have states INIT0, INIT1, RUN; reset enters INIT0; INIT0->INIT1->RUN unconditionally, one cycle each.
REQ-014 In INIT1 the block SHALL load prev from cur without counting, so no step or err can occur before RUN.
REQ-015 In RUN, up transitions (prev->cur, AB) SHALL be 00->10, 10->11, 11->01, 01->00: count+1, m<=0, step=1.
REQ-016 In RUN, down transitions SHALL be 00->01, 01->11, 11->10, 10->00: count-1, m<=1, step=1.
REQ-017 In RUN, prev==cur SHALL leave count and m unchanged, step=0, err=0.
REQ-018 In RUN, both bits changing (00<->11, 01<->10) SHALL set err=1 for one cycle and leave count, m unchanged, step=0.
REQ-019 count SHALL wrap modulo 2^WIDTH: max+1 -> 0, 0-1 -> max.
REQ-020 Latency: an a/b change meeting setup before edge k SHALL update count, step, err at edge k+2.
REQ-021 clr=1 SHALL set count to 0 on the next edge, overriding any same-cycle step; step and err SHALL still report the transition; m SHALL update per REQ-015/016.
REQ-022 step and err SHALL be registered and never both 1 in the same cycle.

Reset
REQ-023 While reset=0, count=0, m=0, step=0, err=0, s1=s2=0, prev=00, and state=INIT0, all asynchronously.
REQ-024 Reset asserted mid-transition SHALL discard all in-flight synchronizer contents; after release the block SHALL restart at INIT0.
REQ-025 Reset release SHALL be synchronous to clk at the system level; the block SHALL not count during the two INIT cycles regardless of a/b.

Verification
REQ-026 Reset release with a=1, b=1 held -> count stays 0, no err, no step through INIT and the following 5 cycles.
REQ-027 Four up steps 00->10->11->01->00, each held 4 cycles, WIDTH=3 -> count 0,1,2,3,4; m=0; four step pulses, each 2 edges after the change.
REQ-028 From count=0, one down step 00->01 -> count=7, m=1, one step pulse (wrap).
REQ-029 From prev=00, drive a and b to 11 together -> err pulses once, count unchanged, no step.
REQ-030 clr=1 in the same cycle as a valid up step from count=5 -> count=0 next edge, step=1, m=0.
REQ-031 Assert reset for one cycle mid-sequence at count=3 -> count=0 immediately; after release, no step for 2 cycles, then counting resumes from 0.
